spi: RTL and testbench
======================

SPI -- requirements
Module: spi

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, giving log2 of the SCK period in clk cycles; legal range >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset; one clock, reset is synchronous and active-high.
REQ-004 The block SHALL have port miso, input, 1 bit, serial data from the slave.
REQ-005 The block SHALL have port mosi, output, 1 bit, serial data to the slave, registered.
REQ-006 The block SHALL have port sck, output, 1 bit, serial clock, registered, idle low.
REQ-007 The block SHALL have port start, input, 1 bit, level request to begin a transfer.
REQ-008 The block SHALL have port data_in, input, 8 bits, byte to transmit, sampled when a transfer is accepted.
REQ-009 The block SHALL have port data_out, output, 8 bits, last received byte, registered, held until the next transfer completes.
REQ-010 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not IDLE.
REQ-011 The block SHALL have port new_data, output, 1 bit, single-cycle pulse when data_out updates.

Function
REQ-012 The block SHALL implement an SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, 8 bits per transfer, no chip-select.
REQ-013 Timing SHALL be P = 2^CLK_DIV clk cycles per SCK period and H = P/2 cycles per half period; an internal CLK_DIV-bit counter sets sck = counter MSB in TRANSFER.
REQ-014 FSM states SHALL be IDLE, WAIT_HALF and TRANSFER.
REQ-015 IDLE: sck = 0 and counter = 0; when start = 1 on an edge, data_in SHALL be latched into the shift register and the FSM SHALL go to WAIT_HALF.
REQ-016 start SHALL be ignored outside IDLE; data_in changes after acceptance SHALL NOT affect the transfer.
REQ-017 WAIT_HALF: the FSM SHALL stay for exactly H cycles with sck = 0, then clear the counter and enter TRANSFER.
REQ-018 TRANSFER, counter = 0 (sck low): mosi SHALL be loaded with the shift register MSB.
REQ-019 TRANSFER, counter = H-1 (next edge raises sck): the shift register SHALL shift left, capturing miso into bit 0.
REQ-020 TRANSFER, counter = P-1: the bit count SHALL increment; after bit 7 the FSM SHALL return to IDLE, load data_out from the shift register and assert new_data for exactly one cycle.
REQ-021 A transfer SHALL occupy H + 8*P cycles of busy = 1 (34 cycles at CLK_DIV = 2); sck SHALL produce exactly 8 rising edges per transfer.
REQ-022 If start is still high on the first IDLE cycle after completion, a new transfer SHALL begin, giving at least one idle cycle between transfers.
REQ-023 mosi SHALL hold its last value between transfers.

Reset
REQ-024 While rst = 1, the FSM SHALL be IDLE, and sck, mosi, busy and new_data SHALL be 0; data_out, the shift register and all counters SHALL be cleared to 0.
REQ-025 Reset asserted mid-transfer SHALL abort immediately: no new_data pulse, and data_out = 0.
REQ-026 rst SHALL take priority over start on the same edge.

Verification
REQ-027 Reset, then data_in = 0xCA, miso = 0, start held for 25 cycles -> mosi at the 8 sck rising edges = 1,1,0,0,1,0,1,0; busy high 34 cycles; one new_data pulse; data_out = 0x00; no second transfer.
REQ-028 Loopback miso = mosi, data_in = 0xCA -> data_out = 0xCA with a single new_data pulse.
REQ-029 miso = 1 constant, data_in = 0x00 -> data_out = 0xFF and mosi = 0 throughout.
REQ-030 start held continuously for 100 cycles -> back-to-back transfers, new_data pulses 35 cycles apart, busy low exactly 1 cycle between transfers.
REQ-031 rst pulsed at cycle 10 of a transfer -> busy, sck, mosi, data_out and new_data all 0 the next cycle; the next start begins a clean full transfer.
REQ-032 data_in changed mid-transfer -> transmitted bits match the byte latched at start.

Source files
------------

// File: rtl/spi.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, 8 bits per transfer, no chip-select.
// Latency: a transfer keeps busy high for H + 8*P clk cycles (P = 2^CLK_DIV, H = P/2).
//    new_data pulses on the cycle after the last one. start is a level; it is only
//    honoured in IDLE, so a held start gives back-to-back transfers one idle cycle apart.
//
// Ports:
//    clk      : system clock, rising edge
//    rst      : synchronous active-high reset
//    miso     : serial data from the slave
//    mosi     : serial data to the slave (registered, holds its value between transfers)
//    sck      : serial clock (registered, idle low)
//    start    : level request to begin a transfer
//    data_in  : byte to transmit, captured when a transfer is accepted
//    data_out : last received byte (registered, held until the next transfer completes)
//    busy     : high whenever the FSM is not IDLE
//    new_data : single-cycle pulse when data_out updates

module spi #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       miso,
   output logic       mosi,
   output logic       sck,
   input  logic       start,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       busy,
   output logic       new_data
);

   localparam int P = 1 << CLK_DIV;
   localparam int H = P / 2;

   localparam logic [CLK_DIV-1:0] CNT_ZERO = '0;
   localparam logic [CLK_DIV-1:0] CNT_ONE  = CLK_DIV'(1);
   localparam logic [CLK_DIV-1:0] CNT_H_M1 = CLK_DIV'(H - 1);
   localparam logic [CLK_DIV-1:0] CNT_P_M1 = CLK_DIV'(P - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_HALF = 2'd1,
      TRANSFER  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CLK_DIV-1:0] cnt_q, cnt_d;
   logic [2:0]         bit_q, bit_d;
   logic [7:0]         sr_q, sr_d;
   logic [7:0]         data_out_q, data_out_d;
   logic               mosi_q, mosi_d;
   logic               sck_q, sck_d;
   logic               new_data_q, new_data_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      sr_d       = sr_q;
      data_out_d = data_out_q;
      mosi_d     = mosi_q;
      sck_d      = 1'b0;
      new_data_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = CNT_ZERO;
            bit_d = 3'd0;
            if (start) begin
               sr_d    = data_in;
               state_d = WAIT_HALF;
            end
         end

         // Half a period of sck-low lead-in so the first mosi bit has setup
         // time before the first rising edge.
         WAIT_HALF: begin
            if (cnt_q == CNT_H_M1) begin
               cnt_d   = CNT_ZERO;
               state_d = TRANSFER;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         TRANSFER: begin
            // Counter wraps naturally at P-1; sck follows the MSB of the
            // counter value that will be in place after this edge.
            cnt_d = cnt_q + CNT_ONE;
            sck_d = cnt_d[CLK_DIV-1];

            if (cnt_q == CNT_ZERO) begin
               mosi_d = sr_q[7];
            end

            // Sample miso on the edge that raises sck.
            if (cnt_q == CNT_H_M1) begin
               sr_d = {sr_q[6:0], miso};
            end

            if (cnt_q == CNT_P_M1) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d    = IDLE;
                  data_out_d = sr_q;
                  new_data_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         sr_q       <= '0;
         data_out_q <= '0;
         mosi_q     <= 1'b0;
         sck_q      <= 1'b0;
         new_data_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         sr_q       <= sr_d;
         data_out_q <= data_out_d;
         mosi_q     <= mosi_d;
         sck_q      <= sck_d;
         new_data_q <= new_data_d;
      end
   end

   assign mosi     = mosi_q;
   assign sck      = sck_q;
   assign data_out = data_out_q;
   assign busy     = (state_q != IDLE);
   assign new_data = new_data_q;

endmodule

// File: tb/tb_spi.sv
// Testbench for spi: randomized transfers against a byte-level reference model.
// Latency: expected results are queued at stimulus time and consumed on new_data.
// Backpressure: none; the stimulus waits on busy with bounded cycle budgets.

module tb_spi;

   localparam int CLK_DIV  = 2;
   localparam int P        = 1 << CLK_DIV;
   localparam int H        = P / 2;
   localparam int XFER_LEN = H + 8 * P;

   logic       clk = 1'b0;
   logic       rst;
   logic       miso;
   logic       mosi;
   logic       sck;
   logic       start;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       busy;
   logic       new_data;

   spi #(.CLK_DIV(CLK_DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .miso     (miso),
      .mosi     (mosi),
      .sck      (sck),
      .start    (start),
      .data_in  (data_in),
      .data_out (data_out),
      .busy     (busy),
      .new_data (new_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: each transfer is summarised by the byte that must appear
   // on mosi (MSB first) and the byte the slave presents on miso.
   typedef struct {
      logic [7:0] tx;
      logic [7:0] rx;
   } exp_t;
   exp_t exp_q[$];

   // Slave model: presents cur_rx MSB first, changing miso only after sck falls.
   logic [7:0] cur_rx = 8'h00;
   bit         loopback = 1'b0;
   logic       miso_drv = 1'b0;
   logic [7:0] slv_sh = 8'h00;
   logic       slv_busy_p = 1'b0;
   logic       slv_sck_p = 1'b0;

   assign miso = loopback ? mosi : miso_drv;

   always @(negedge clk) begin
      if (busy && !slv_busy_p) begin
         slv_sh   = cur_rx;
         miso_drv = slv_sh[7];
      end else if (!sck && slv_sck_p) begin
         slv_sh   = {slv_sh[6:0], 1'b0};
         miso_drv = slv_sh[7];
      end
      slv_busy_p = busy;
      slv_sck_p  = sck;
   end

   // Monitor: observes the serial lines and checks each completed transfer.
   logic       mon_busy_p = 1'b0;
   logic       mon_sck_p = 1'b0;
   int         busy_len = 0;
   int         rises = 0;
   logic [7:0] mosi_bits = 8'h00;
   bit         b2b_mode = 1'b0;
   int         last_nd = -1;

   always @(negedge clk) begin
      exp_t e;
      if (busy && !mon_busy_p) begin
         busy_len  = 0;
         rises     = 0;
         mosi_bits = 8'h00;
      end
      if (busy) busy_len++;
      if (sck && !mon_sck_p) begin
         rises++;
         mosi_bits = {mosi_bits[6:0], mosi};
      end
      if (new_data) begin
         if (exp_q.size() == 0) begin
            check("unexpected_new_data", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("data_out", {24'd0, data_out}, {24'd0, e.rx});
            check("mosi_bits", {24'd0, mosi_bits}, {24'd0, e.tx});
            check("sck_rises", rises, 8);
            check("busy_len", busy_len, XFER_LEN);
         end
         if (b2b_mode && last_nd >= 0) begin
            check("b2b_interval", cyc - last_nd, XFER_LEN + 1);
         end
         last_nd = cyc;
      end
      mon_busy_p = busy;
      mon_sck_p  = sck;
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy) check("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic do_xfer(input logic [7:0] tx, input logic [7:0] rx, input bit lb,
                          input int hold, input bit poke);
      exp_t e;
      wait_idle(200);
      @(posedge clk);
      #1;
      loopback = lb;
      cur_rx   = rx;
      data_in  = tx;
      start    = 1'b1;
      e.tx = tx;
      e.rx = lb ? tx : rx;
      exp_q.push_back(e);
      repeat (hold) @(posedge clk);
      #1;
      start   = 1'b0;
      data_in = 8'($urandom);
      if (poke) begin
         repeat (8) @(posedge clk);
         #1;
         start   = 1'b1;
         data_in = 8'($urandom);
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      wait_idle(200);
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b1;
      data_in = 8'hA5;

      // Reset holds everything at zero, even with start asserted.
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_sck", {31'd0, sck}, 32'd0);
      check("rst_mosi", {31'd0, mosi}, 32'd0);
      check("rst_new_data", {31'd0, new_data}, 32'd0);
      check("rst_data_out", {24'd0, data_out}, 32'd0);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("idle_after_rst", {31'd0, busy}, 32'd0);

      // 0xCA with miso low, start held 25 cycles: exactly one transfer.
      do_xfer(8'hCA, 8'h00, 1'b0, 25, 1'b0);
      repeat (5) begin
         @(posedge clk);
         #1;
         check("no_second_xfer", {31'd0, busy}, 32'd0);
      end

      // Loopback returns the transmitted byte.
      do_xfer(8'hCA, 8'h00, 1'b1, 1, 1'b0);

      // Constant miso high with all-zero data.
      do_xfer(8'h00, 8'hFF, 1'b0, 1, 1'b0);
      check("mosi_low_after_zero", {31'd0, mosi}, 32'd0);

      // Randomized transfers; data_in scrambled after acceptance and a stray
      // start pulse issued mid-transfer.
      for (int i = 0; i < 10; i++) begin
         logic [7:0] tx;
         logic [7:0] rx;
         int         mode;
         tx   = 8'($urandom);
         mode = $urandom_range(0, 2);
         rx   = (mode == 2) ? (($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00) : 8'($urandom);
         do_xfer(tx, rx, mode == 1, $urandom_range(1, 20), 1'b1);
      end

      // start held for 100 cycles: three back-to-back transfers.
      wait_idle(200);
      @(posedge clk);
      #1;
      b2b_mode = 1'b1;
      last_nd  = -1;
      loopback = 1'b0;
      cur_rx   = 8'h3C;
      data_in  = 8'h5A;
      start    = 1'b1;
      for (int i = 0; i < 3; i++) exp_q.push_back('{tx: 8'h5A, rx: 8'h3C});
      repeat (100) @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle(200);
      repeat (3) @(posedge clk);
      #1;
      b2b_mode = 1'b0;
      check("b2b_queue_drained", exp_q.size(), 0);

      // Reset at cycle 10 of a transfer aborts it cleanly.
      @(posedge clk);
      #1;
      data_in = 8'hF0;
      cur_rx  = 8'h81;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_sck", {31'd0, sck}, 32'd0);
      check("abort_mosi", {31'd0, mosi}, 32'd0);
      check("abort_data_out", {24'd0, data_out}, 32'd0);
      check("abort_new_data", {31'd0, new_data}, 32'd0);
      repeat (5) begin
         @(posedge clk);
         #1;
         check("abort_no_pulse", {31'd0, new_data}, 32'd0);
      end

      // Next start after the abort is a clean full transfer.
      do_xfer(8'h96, 8'h69, 1'b0, 1, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got cycle %0d required < 20000", cyc);
      $fatal(1, "timeout");
   end

endmodule
